// File: rtl/apb_bridge_pkg.sv
// Shared constants for the AHB-Lite to APB bridge: FSM state codes,
// HTRANS encodings, slave count limit and AHB response values.
package apb_bridge_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ERR1   = 3'd3;
  localparam logic [2:0] ST_ERR2   = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int NUM_SLAVES_MAX = 9;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slot decoder: maps an AHB address onto one of the
// NUM_SLAVES 2**SLOT_BITS-byte windows above BASE_ADDR.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          SLOT_BITS  = 12,
  parameter int          NUM_SLAVES = NUM_SLAVES_MAX
)(
  input  logic [31:0]           haddr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] psel_onehot
);

  logic [3:0]           slot_s;
  logic                 region_s;
  logic [SLOT_BITS-1:0] unused_offset_s;

  assign slot_s          = haddr[SLOT_BITS+3:SLOT_BITS];
  assign region_s        = (haddr[31:SLOT_BITS+4] == BASE_ADDR[31:SLOT_BITS+4]);
  assign unused_offset_s = haddr[SLOT_BITS-1:0];

  // Hit only inside the segment and on a populated slot; select is one-hot or zero.
  always_comb begin
    hit         = region_s && ({1'b0, slot_s} < 5'(NUM_SLAVES));
    psel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit && (slot_s == 4'(i))) begin
        psel_onehot[i] = 1'b1;
      end else begin
        psel_onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns single AHB transfers into APB SETUP/ACCESS
// sequences, stretching the AHB data phase until the APB slave answers.
// Slave errors, decode misses and timeouts become a two-cycle AHB ERROR.
module ahb_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          SLOT_BITS  = 12,
  parameter int          NUM_SLAVES = NUM_SLAVES_MAX,
  parameter int          TIMEOUT    = 255
)(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic                  PRESP,
  input  logic [31:0]           PRDATA
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [31:0]           paddr_r;
  logic                  pwrite_r;
  logic [NUM_SLAVES-1:0] psel_r;
  logic                  penable_r;

  logic                  hit_s;
  logic [NUM_SLAVES-1:0] psel_dec_s;
  logic                  done_ok_s;
  logic                  slv_err_s;
  logic                  timeout_s;
  logic                  can_accept_s;
  logic                  accept_s;
  logic                  hreadyout_s;
  logic                  hresp_s;

  apb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_BITS  (SLOT_BITS),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .haddr       (HADDR),
    .hit         (hit_s),
    .psel_onehot (psel_dec_s)
  );

  // Outcome of the current ACCESS cycle: clean completion, slave error or timeout.
  always_comb begin
    done_ok_s = 1'b0;
    slv_err_s = 1'b0;
    timeout_s = 1'b0;
    if (state_r == ST_ACCESS) begin
      done_ok_s = PREADY & ~PRESP;
      slv_err_s = PREADY & PRESP;
      timeout_s = (TIMEOUT != 0) && !PREADY && (cnt_r == CNT_LAST);
    end else begin
      done_ok_s = 1'b0;
      slv_err_s = 1'b0;
      timeout_s = 1'b0;
    end
  end

  assign can_accept_s = (state_r == ST_IDLE) || done_ok_s || (state_r == ST_ERR2);
  assign accept_s     = HSEL && HREADY && is_active(HTRANS) && can_accept_s;

  // Next-state selection; accepted transfers go to SETUP on a hit, ERR1 on a miss.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = hit_s ? ST_SETUP : ST_ERR1;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_err_s || timeout_s) state_nxt_s = ST_ERR2;
        else if (done_ok_s) begin
          if (accept_s) state_nxt_s = hit_s ? ST_SETUP : ST_ERR1;
          else          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_ERR2: begin
        if (accept_s) state_nxt_s = hit_s ? ST_SETUP : ST_ERR1;
        else          state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // AHB data-phase response; the first ERROR cycle stalls, the second releases.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = RESP_OKAY;
    case (state_r)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
        hresp_s     = RESP_OKAY;
      end
      ST_SETUP: begin
        hreadyout_s = 1'b0;
        hresp_s     = RESP_OKAY;
      end
      ST_ACCESS: begin
        hreadyout_s = done_ok_s;
        hresp_s     = (slv_err_s || timeout_s) ? RESP_ERROR : RESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = RESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = RESP_ERROR;
      end
      default: begin
        hreadyout_s = 1'b1;
        hresp_s     = RESP_OKAY;
      end
    endcase
  end

  // State, timeout counter and registered APB control; reset abandons any transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      paddr_r   <= 32'h0000_0000;
      pwrite_r  <= 1'b0;
      psel_r    <= '0;
      penable_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        paddr_r  <= HADDR;
        pwrite_r <= HWRITE;
        psel_r   <= hit_s ? psel_dec_s : '0;
      end else if (state_nxt_s != ST_ACCESS) begin
        psel_r <= '0;
      end else begin
        psel_r <= psel_r;
      end
      penable_r <= (state_nxt_s == ST_ACCESS);
      if (state_nxt_s == ST_SETUP) begin
        cnt_r <= '0;
      end else if ((state_r == ST_ACCESS) && !PREADY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign HREADYOUT = hreadyout_s;
  assign HRESP     = hresp_s;
  assign HRDATA    = PRDATA;
  assign PADDR     = paddr_r;
  assign PWRITE    = pwrite_r;
  assign PWDATA    = HWDATA;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge (TIMEOUT=4): a table of single
// transfers run through a scoreboard, plus hand-written sequences for
// back-to-back transfers, ignored BUSY cycles and reset during ACCESS.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [8:0]  PSEL;
  logic        PENABLE;
  logic        PREADY;
  logic        PRESP;
  logic [31:0] PRDATA;

  ahb_apb_bridge #(
    .BASE_ADDR  (32'h4000_0000),
    .SLOT_BITS  (12),
    .NUM_SLAVES (9),
    .TIMEOUT    (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .PRESP     (PRESP),
    .PRDATA    (PRDATA)
  );

  // Single-slave AHB system: the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic        slv_err;
    logic        hang;
    logic [8:0]  exp_psel;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[9];
  vec_t sb_q[$];

  int passed = 0;
  int total  = 0;

  int          slv_waits;
  logic        slv_err;
  logic        slv_hang;
  logic [31:0] slv_rdata;
  int          acc_cnt;
  logic        rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Advance to the next falling edge, update the APB slave model, let outputs settle.
  task automatic step();
    @(negedge HCLK);
    if (PSEL != 9'h000 && PENABLE) begin
      acc_cnt++;
      rdy = !slv_hang && (acc_cnt > slv_waits);
    end else begin
      acc_cnt = 0;
      rdy     = 1'b0;
    end
    PREADY = rdy;
    PRESP  = rdy & slv_err;
    PRDATA = slv_rdata;
    #1;
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, "_idle_hreadyout"}, HREADYOUT, 1'b1);
    check({tag, "_idle_hresp"}, HRESP, 1'b0);
    check({tag, "_idle_psel"}, PSEL, 9'h000);
  endtask

  task automatic run_vec(input vec_t v);
    int         waits;
    logic [8:0] psel_seen;
    bit         setup_ok;
    bit         apb_ok;
    bit         last_resp;
    bit         done;
    vec_t       e;
    step();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.write;
    HWDATA = v.write ? v.data : 32'h0000_0000;
    slv_waits = v.waits; slv_err = v.slv_err; slv_hang = v.hang; slv_rdata = v.data;
    sb_q.push_back(v);
    waits = 0; psel_seen = 9'h000; setup_ok = 1'b1; apb_ok = 1'b1;
    last_resp = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (c == 0) begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (PSEL != 9'h000) begin
        if (psel_seen == 9'h000 && PENABLE !== 1'b0) setup_ok = 1'b0;
        psel_seen |= PSEL;
        if (PADDR !== v.addr || PWRITE !== v.write || (v.write && PWDATA !== v.data)) apb_ok = 1'b0;
      end
      if (HREADYOUT) done = 1'b1;
      else begin
        waits++;
        last_resp = HRESP;
      end
    end
    e = sb_q.pop_front();
    check("xfer_done", done, 1'b1);
    check("xfer_wait_states", waits, e.exp_waits);
    check("xfer_hresp", HRESP, e.exp_err);
    check("xfer_psel", psel_seen, e.exp_psel);
    if (e.exp_err) begin
      check("err_first_cycle_hresp", last_resp, 1'b1);
      check("err2_psel", PSEL, 9'h000);
      check("err2_penable", PENABLE, 1'b0);
    end else if (!e.write) begin
      check("xfer_hrdata", HRDATA, e.data);
    end
    if (e.exp_psel != 9'h000) begin
      check("xfer_setup_phase", setup_ok, 1'b1);
      check("xfer_apb_fields", apb_ok, 1'b1);
    end
    idle_check("xfer");
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h4000_3004, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 9'h008, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h4000_8000, 32'h1234_5678, 3, 1'b0, 1'b0, 9'h100, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h4000_9000, 32'h0BAD_0BAD, 0, 1'b0, 1'b0, 9'h000, 1'b1, 1};
    vecs[3] = '{1'b1, 32'h4000_2010, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 9'h004, 1'b1, 2};
    vecs[4] = '{1'b0, 32'h4000_5000, 32'h5555_AAAA, 0, 1'b0, 1'b1, 9'h020, 1'b1, 5};
    vecs[5] = '{1'b0, 32'h4000_0FFC, 32'h0F0F_0F0F, 1, 1'b1, 1'b0, 9'h001, 1'b1, 3};
    vecs[6] = '{1'b1, 32'h5000_1000, 32'h7777_7777, 0, 1'b0, 1'b0, 9'h000, 1'b1, 1};
    vecs[7] = '{1'b0, 32'h4000_7ABC, 32'hA5A5_0F0F, 2, 1'b0, 1'b0, 9'h080, 1'b0, 3};
    vecs[8] = '{1'b0, 32'h4000_F000, 32'h1111_2222, 0, 1'b0, 1'b0, 9'h000, 1'b1, 1};

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = 32'h0; PREADY = 1'b0; PRESP = 1'b0; PRDATA = 32'h0;
    slv_waits = 0; slv_err = 1'b0; slv_hang = 1'b0; slv_rdata = 32'h0;
    acc_cnt = 0; rdy = 1'b0;

    #2;
    check("rst_psel", PSEL, 9'h000);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp", HRESP, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwrite", PWRITE, 1'b0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // BUSY transfer with HSEL set must be ignored with OKAY.
    step();
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h4000_1000; HWRITE = 1'b1;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    check("busy_hreadyout", HREADYOUT, 1'b1);
    check("busy_hresp", HRESP, 1'b0);
    check("busy_psel", PSEL, 9'h000);

    // Back-to-back writes to slot 0 then slot 1.
    slv_waits = 0; slv_err = 1'b0; slv_hang = 1'b0; slv_rdata = 32'h0;
    step();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0000; HWRITE = 1'b1; HWDATA = 32'h1111_0000;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    check("b2b_first_setup_psel", PSEL, 9'h001);
    check("b2b_first_setup_penable", PENABLE, 1'b0);
    step();
    check("b2b_first_access_penable", PENABLE, 1'b1);
    check("b2b_first_done", HREADYOUT, 1'b1);
    check("b2b_first_pwdata", PWDATA, 32'h1111_0000);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_1008; HWRITE = 1'b1;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h2222_0000;
    #1;
    check("b2b_second_setup_psel", PSEL, 9'h002);
    check("b2b_second_setup_penable", PENABLE, 1'b0);
    check("b2b_second_setup_stall", HREADYOUT, 1'b0);
    check("b2b_second_paddr", PADDR, 32'h4000_1008);
    step();
    check("b2b_second_done", HREADYOUT, 1'b1);
    check("b2b_second_hresp", HRESP, 1'b0);
    check("b2b_second_pwdata", PWDATA, 32'h2222_0000);
    check("b2b_second_access_psel", PSEL, 9'h002);
    idle_check("b2b");

    // Reset asserted during ACCESS clears the APB side without a clock edge.
    slv_hang = 1'b1;
    step();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_2000; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    step();
    check("rst_mid_pre_penable", PENABLE, 1'b1);
    check("rst_mid_pre_psel", PSEL, 9'h004);
    #1 HRESETn = 1'b0;
    #1;
    check("rst_mid_psel", PSEL, 9'h000);
    check("rst_mid_penable", PENABLE, 1'b0);
    check("rst_mid_hreadyout", HREADYOUT, 1'b1);
    check("rst_mid_hresp", HRESP, 1'b0);
    check("rst_mid_paddr", PADDR, 32'h0);
    step();
    HRESETn = 1'b1; slv_hang = 1'b0;
    idle_check("rst_mid");

    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB-Lite slave that converts single AHB transfers into APB SETUP/ACCESS sequences for the nine-slave peripheral segment.
- Decodes the slot from HADDR and drives one-hot PSEL[8:0].
- Sequences PENABLE and stretches the AHB data phase with HREADYOUT.
- Converts PSLVERR, decode misses and slave timeouts into a two-cycle AHB ERROR.
- Sits between the AHB interconnect and the APB read-data/response mux. It consumes that mux's PRDATA/PREADY/PRESP outputs.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the APB segment.
SLOT_BITS, 12, log2 of the per-slave window (4 KB).
NUM_SLAVES, 9, number of PSEL lines. Slots 0..NUM_SLAVES-1 are mapped.
TIMEOUT, 255, ACCESS cycles without PREADY before an error is forced. 0 disables the timeout.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  segment select from AHB decoder
HADDR  in  32  AHB address
HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ or SEQ
HWRITE  in  1  AHB direction
HWDATA  in  32  AHB write data, valid in data phase
HREADY  in  1  AHB bus ready; previous transfer complete
HREADYOUT  out  1  data-phase ready to AHB
HRESP  out  1  AHB error response
HRDATA  out  32  read data to AHB
PADDR  out  32  APB address (registered)
PWRITE  out  1  APB direction (registered)
PWDATA  out  32  APB write data
PSEL  out  NUM_SLAVES  one-hot APB select
PENABLE  out  1  APB access phase
PREADY  in  1  muxed slave ready
PRESP  in  1  muxed slave error (PSLVERR)
PRDATA  in  32  muxed slave read data

Behaviour:
- Reset (async, HRESETn=0):
  - State is IDLE.
  - PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, PADDR=0, PWRITE=0, timeout counter=0.
  - Reset mid-transfer drops PSEL/PENABLE immediately. The slave transfer is abandoned.
- Accept condition: HSEL & HREADY & HTRANS[1] in IDLE, at ACCESS completion (HREADYOUT=1), or in ERR2. IDLE/BUSY HTRANS is ignored with an OKAY response.
- On accept:
  - Register PADDR<=HADDR and PWRITE<=HWRITE.
  - Decode hit if HADDR[31:SLOT_BITS+4]==BASE_ADDR[31:SLOT_BITS+4] and slot=HADDR[SLOT_BITS+3:SLOT_BITS]<NUM_SLAVES.
  - Hit goes to SETUP with PSEL<=onehot(slot). Miss goes to ERR1 with PSEL stays 0.
- States (one-hot or encoded: IDLE, SETUP, ACCESS, ERR1, ERR2):
  - IDLE: HREADYOUT=1, HRESP=0.
  - SETUP: PSEL high, PENABLE=0, HREADYOUT=0. Next state is always ACCESS.
  - ACCESS: PSEL high, PENABLE=1, timeout counter increments each cycle PREADY=0.
    - PREADY=1, PRESP=0: HREADYOUT=1, HRDATA=PRDATA in this cycle. Next state is SETUP on back-to-back accept, else IDLE with PSEL/PENABLE cleared.
    - PREADY=1, PRESP=1: HRESP=1, HREADYOUT=0. Next state is ERR2.
    - PREADY=0 and counter==TIMEOUT-1 (TIMEOUT≠0): HRESP=1, HREADYOUT=0. Next state is ERR2. PSEL/PENABLE drop on the next edge.
    - PREADY=0 otherwise: hold with HREADYOUT=0.
  - ERR1: HRESP=1, HREADYOUT=0. Next state is ERR2.
  - ERR2: HRESP=1, HREADYOUT=1, PSEL=0, PENABLE=0. Next state is SETUP/ERR1 on accept, else IDLE.
- Counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT+1), minimum 1.
- PWDATA=HWDATA combinationally. The AHB master holds HWDATA stable while HREADYOUT=0, so it is valid throughout SETUP and ACCESS.
- HRDATA=PRDATA combinationally. It is only meaningful in the completing ACCESS cycle.
- Latency: minimum 2 data-phase cycles per transfer (SETUP + ACCESS). An error adds one cycle.
- PADDR/PWRITE are unchanged outside an accept, so they are held through wait states.

Decomposition:
- Package apb_bridge_pkg:
  - state enum (IDLE, SETUP, ACCESS, ERR1, ERR2);
  - HTRANS codes;
  - NUM_SLAVES_MAX=9;
  - AHB response constants.
- Sub-module apb_addr_decode: combinational HADDR→{hit, onehot PSEL}, parameterised by BASE_ADDR/SLOT_BITS/NUM_SLAVES.

Test Plan:
1. Write 0x4000_3004, HWDATA=0xDEADBEEF, slave PREADY=1 immediately:
   - PSEL=9'h008 for 2 cycles, PENABLE in cycle 2, PWRITE=1, PWDATA=0xDEADBEEF.
   - HREADYOUT low 1 cycle, then high with HRESP=0.
2. Read 0x4000_8000 with PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678:
   - PSEL=9'h100, HREADYOUT=0 for 4 cycles.
   - HRDATA=0x1234_5678 when HREADYOUT=1.
3. Read 0x4000_9000 (slot 9, miss):
   - PSEL stays 0.
   - HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE.
4. Slave returns PREADY=1, PRESP=1: two-cycle ERROR sequence, PSEL/PENABLE low in ERR2.
5. TIMEOUT=4, PREADY held 0: error asserted on the 4th ACCESS cycle, PSEL dropped on the next edge.
6. Back-to-back writes to slots 0 then 1, plus HRESETn pulse during ACCESS:
   - SETUP of the second write directly follows the first completion with PSEL=9'h002.
   - Reset forces PSEL=0, PENABLE=0, HREADYOUT=1 asynchronously.
